// File: rtl/bin_frac_norm_round_pkg.sv
// Shared widths, state encoding and result payload for the binary-fraction
// normalise/round stage.
package bin_frac_norm_round_pkg;

  localparam int unsigned W_IN   = 7;
  localparam int unsigned PROD_W = 2 * W_IN - 1;
  localparam int unsigned MAG_W  = PROD_W - 1;
  localparam int unsigned FRAC_W = W_IN - 1;
  localparam int unsigned EXP_W  = 5;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [FRAC_W-1:0] frac;
  } frac_t;

endpackage

// File: rtl/bin_frac_norm_round_rne.sv
// Round-to-nearest-even of a normalised 12-bit magnitude down to 6 bits.
// A carry out means the magnitude rolled over to 1.0, returned as 0.100000.
module bin_frac_norm_round_rne
  import bin_frac_norm_round_pkg::*;
(
  input  logic [MAG_W-1:0]  mag,
  output logic [FRAC_W-1:0] frac_c,
  output logic              carry_c
);

  logic [FRAC_W-1:0] keep;
  logic              rbit;
  logic              sticky;
  logic              inc;
  logic [FRAC_W:0]   sum;

  assign keep    = mag[MAG_W-1:MAG_W-FRAC_W];
  assign rbit    = mag[MAG_W-FRAC_W-1];
  assign sticky  = |mag[MAG_W-FRAC_W-2:0];
  assign inc     = rbit & (sticky | keep[0]);
  assign sum     = {1'b0, keep} + (FRAC_W+1)'(inc);
  assign carry_c = sum[FRAC_W];
  assign frac_c  = sum[FRAC_W] ? {1'b1, (FRAC_W-1)'(0)} : sum[FRAC_W-1:0];

endmodule

// File: rtl/bin_frac_norm_round.sv
// Post-multiply stage: normalises the product magnitude one bit per clock,
// then rounds to a 7-bit sign-magnitude fraction plus exponent.
module bin_frac_norm_round
  import bin_frac_norm_round_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PROD_W-1:0] product,
  output logic              busy,
  output logic              done,
  output logic [W_IN-1:0]   result,
  output logic [EXP_W-1:0]  exp,
  output logic              zero
);

  state_t            state_q, state_d;
  logic [MAG_W-1:0]  mag_q, mag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  frac_t             result_q, result_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              zero_q, zero_d;

  logic [FRAC_W-1:0] rnd_frac_c;
  logic              rnd_carry_c;

  bin_frac_norm_round_rne u_rne (
    .mag     (mag_q),
    .frac_c  (rnd_frac_c),
    .carry_c (rnd_carry_c)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      exp_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      exp_q    <= exp_d;
      zero_q   <= zero_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    exp_d    = exp_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = product[PROD_W-1];
          mag_d   = product[MAG_W-1:0];
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A zero magnitude never reaches bit 11, so it exits immediately
        if (mag_q[MAG_W-1] || (mag_q == '0)) begin
          state_d = ROUND;
        end else begin
          mag_d = {mag_q[MAG_W-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ROUND: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
        if (mag_q == '0) begin
          result_d = '0;
          exp_d    = '0;
          zero_d   = 1'b1;
        end else begin
          result_d.sign = sign_q;
          result_d.frac = rnd_frac_c;
          exp_d         = EXP_W'(0) - EXP_W'(cnt_q) + EXP_W'(rnd_carry_c);
          zero_d        = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign exp    = exp_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_bin_frac_norm_round.sv
// Randomised bench for bin_frac_norm_round against an arithmetic reference.
module tb_bin_frac_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [12:0] product;
  logic        busy;
  logic        done;
  logic [6:0]  result;
  logic [4:0]  exp;
  logic        zero;

  int checks = 0;
  int errors = 0;

  logic [6:0] last_r;
  logic [4:0] last_e;
  logic       last_z;

  bin_frac_norm_round dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .product (product),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .exp     (exp),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Value semantics: normalise to [0.5,1), round to 6 fraction bits, ties to even.
  function automatic void model(input logic [12:0] p, output logic [6:0] r,
                                output logic [4:0] e, output logic z, output int k);
    int mag;
    int n;
    int q;
    int rem;
    int ex;
    mag = int'(p[11:0]);
    k = 0;
    if (mag == 0) begin
      r = 7'd0; e = 5'd0; z = 1'b1;
      return;
    end
    n = mag;
    while (n < 2048) begin
      n = n * 2;
      k++;
    end
    q   = n / 64;
    rem = n % 64;
    if (rem > 32 || (rem == 32 && (q % 2) == 1)) q++;
    ex = -k;
    if (q == 64) begin
      q  = 32;
      ex = ex + 1;
    end
    r = {p[12], 6'(q)};
    e = 5'(ex);
    z = 1'b0;
  endfunction

  // Launch one product from a negedge; optional extra start at edge t+inj_n
  // or reset at edge t+rst_at. Returns at the negedge of the done cycle.
  task automatic run_op(input logic [12:0] p, input int inj_n, input int rst_at);
    logic [6:0] er;
    logic [4:0] ee;
    logic       ez;
    int         k;
    int         lat;
    int         extra;
    model(p, er, ee, ez, k);
    start   = 1'b1;
    product = p;
    @(negedge clk);
    start = 1'b0;
    check("hold_result", result, last_r);
    check("hold_exp", exp, last_e);
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      start = (n == inj_n);
      if (n == inj_n) product = 13'($urandom);
      rst = (n == rst_at);
      @(negedge clk);
      start = 1'b0;
      if (n == rst_at) begin
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_exp", exp, 0);
        check("rst_zero", zero, 0);
        extra = 0;
        for (int i = 0; i < 15; i++) begin
          @(negedge clk);
          if (done) extra++;
        end
        check("rst_no_done", extra, 0);
        last_r = 7'd0; last_e = 5'd0; last_z = 1'b0;
        return;
      end
      if (done) lat = n;
      else if (n == 1 || n == k + 1) check("busy_during", busy, 1);
    end
    check("latency", lat, k + 2);
    check("result", result, er);
    check("exp", exp, ee);
    check("zero", zero, ez);
    check("busy_at_done", busy, 0);
    last_r = er; last_e = ee; last_z = ez;
    if (inj_n > 0) begin
      extra = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("ignored_start", extra, 0);
    end
  endtask

  initial begin
    logic [12:0] p;
    rst = 1'b1;
    start = 1'b0;
    product = '0;
    last_r = 7'd0; last_e = 5'd0; last_z = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_exp", exp, 0);
    check("reset_zero", zero, 0);

    // Directed corners
    run_op(13'b0_000000001000, 0, 0);
    check("dir_8shift_r", result, 7'b0100000);
    check("dir_8shift_e", exp, 5'b11000);
    run_op(13'b1_100000000000, 0, 0);
    check("dir_noshift_r", result, 7'b1100000);
    run_op(13'b0_111111100000, 0, 0);
    check("dir_carry_e", exp, 5'b00001);
    run_op(13'b0_101010100000, 0, 0);
    check("dir_tie_even", result, 7'b0101010);
    run_op(13'b0_101010100001, 0, 0);
    check("dir_above_tie", result, 7'b0101011);
    run_op(13'b1_000000000000, 0, 0);
    check("dir_negzero_z", zero, 1);
    run_op(13'b0_000000000001, 0, 0);

    // Start during busy is ignored; reset mid-flight aborts
    @(negedge clk);
    run_op(13'b0_000000001000, 3, 0);
    run_op(13'b0_000000001000, 0, 4);

    // Back-to-back: next start in the done cycle
    run_op(13'b1_000011110000, 0, 0);
    run_op(13'b0_000000010111, 0, 0);

    for (int i = 0; i < 150; i++) begin
      p = 13'($urandom);
      p[11:0] = p[11:0] >> $urandom_range(0, 12);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(p, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
